// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen: parametrised VGA raster timing (pixel/line counters, sync, blanking, strobes).
// Optional 8-bit frame counter port is enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int H_W       = 10,
  parameter int V_W       = 10,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic           Clk,
  input  logic           reset,
  input  logic           pix_en,
  output logic [H_W-1:0] pix_x,
  output logic [V_W-1:0] pix_y,
  output logic           hsync,
  output logic           vsync,
  output logic           video_on,
  output logic           line_end,
  output logic           frame_end
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]     frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 32'd1);
  localparam logic [H_W-1:0] H_VIS_END  = H_W'(H_VISIBLE);
  localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_VISIBLE + H_FRONT);
  localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [H_W-1:0] H_ONE      = H_W'(32'd1);

  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 32'd1);
  localparam logic [V_W-1:0] V_VIS_END  = V_W'(V_VISIBLE);
  localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_VISIBLE + V_FRONT);
  localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [V_W-1:0] V_ONE      = V_W'(32'd1);

  logic [H_W-1:0] hcount_r;
  logic [V_W-1:0] vcount_r;
  logic           h_last_s;
  logic           v_last_s;
  logic           h_sync_s;
  logic           v_sync_s;

  // Raster counters: hcount wraps at H_TOTAL-1, vcount steps on each hcount wrap.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      hcount_r <= '0;
      vcount_r <= '0;
    end else if (pix_en) begin
      if (h_last_s) begin
        hcount_r <= '0;
        if (v_last_s) begin
          vcount_r <= '0;
        end else begin
          vcount_r <= vcount_r + V_ONE;
        end
      end else begin
        hcount_r <= hcount_r + H_ONE;
      end
    end else begin
      hcount_r <= hcount_r;
      vcount_r <= vcount_r;
    end
  end

  // Decodes of the current counter state; zero skew against pix_x/pix_y.
  always_comb begin
    h_last_s  = (hcount_r == H_LAST);
    v_last_s  = (vcount_r == V_LAST);
    h_sync_s  = (hcount_r >= H_SYNC_BEG) && (hcount_r < H_SYNC_END);
    v_sync_s  = (vcount_r >= V_SYNC_BEG) && (vcount_r < V_SYNC_END);
    pix_x     = hcount_r;
    pix_y     = vcount_r;
    if (h_sync_s) begin
      hsync = SYNC_POL;
    end else begin
      hsync = ~SYNC_POL;
    end
    if (v_sync_s) begin
      vsync = SYNC_POL;
    end else begin
      vsync = ~SYNC_POL;
    end
    video_on  = (hcount_r < H_VIS_END) && (vcount_r < V_VIS_END);
    line_end  = pix_en && h_last_s;
    frame_end = pix_en && h_last_s && v_last_s;
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_r;

  // Frame counter: free-running modulo 256, one step per frame_end.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_r <= 8'd0;
    end else if (frame_end) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen: a default instance, a short-frame instance (default line timing)
// and a tiny SYNC_POL=1 instance, all sharing reset and pix_en.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        hs;
    logic        vs;
    logic        von;
    logic        le;
    logic        fe;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
    obs_t c;
  } exp_t;

  typedef struct {
    int   tick;
    logic pe;
    obs_t exp;
  } vec_t;

  logic Clk = 1'b0;
  logic reset;
  logic pix_en;

  always #5 Clk = ~Clk;

  logic [9:0] a_x, a_y;
  logic       a_hs, a_vs, a_von, a_le, a_fe;
  logic [9:0] b_x;
  logic [3:0] b_y;
  logic       b_hs, b_vs, b_von, b_le, b_fe;
  logic [2:0] c_x, c_y;
  logic       c_hs, c_vs, c_von, c_le, c_fe;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] a_fc, b_fc, c_fc;
`endif

  vga_timing_gen dut_a (
    .Clk(Clk), .reset(reset), .pix_en(pix_en), .pix_x(a_x), .pix_y(a_y),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .line_end(a_le), .frame_end(a_fe)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(a_fc)
`endif
  );

  vga_timing_gen #(
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .V_W(4)
  ) dut_b (
    .Clk(Clk), .reset(reset), .pix_en(pix_en), .pix_x(b_x), .pix_y(b_y),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .line_end(b_le), .frame_end(b_fe)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(b_fc)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_W(3), .V_W(3), .SYNC_POL(1'b1)
  ) dut_c (
    .Clk(Clk), .reset(reset), .pix_en(pix_en), .pix_x(c_x), .pix_y(c_y),
    .hsync(c_hs), .vsync(c_vs), .video_on(c_von), .line_end(c_le), .frame_end(c_fe)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(c_fc)
`endif
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   tick = 0;
  int   cyc = 0;
  logic stat_b_en = 1'b0;
  logic stat_c_en = 1'b0;
  int   vo_b = 0, hs_lo_b = 0, vs_lo_b = 0, le_b = 0, fe_b = 0;
  int   vo_c = 0, hs_hi_c = 0, vs_hi_c = 0, fe_c = 0;
  int   le_cyc_q[$];
  exp_t sb_q[$];
  vec_t vecs[17];

  function automatic obs_t mk(int x, int y, logic hs, logic vs, logic von, logic le, logic fe);
    obs_t o;
    o.x = 16'(x); o.y = 16'(y);
    o.hs = hs; o.vs = vs; o.von = von; o.le = le; o.fe = fe;
    return o;
  endfunction

  // Reference: position derived from the tick count since reset by division/modulo.
  function automatic obs_t model(int t, int ht, int hv, int hsb, int hse,
                                 int vt, int vv, int vsb, int vse, logic pol, logic pe);
    obs_t o;
    int   h;
    int   v;
    h = t % ht;
    v = (t / ht) % vt;
    o.x   = 16'(h);
    o.y   = 16'(v);
    o.hs  = (h >= hsb && h < hse) ? pol : ~pol;
    o.vs  = (v >= vsb && v < vse) ? pol : ~pol;
    o.von = (h < hv) && (v < vv);
    o.le  = pe && (h == ht - 1);
    o.fe  = o.le && (v == vt - 1);
    return o;
  endfunction

  function automatic exp_t exp_all(int t, logic pe);
    exp_t e;
    e.a = model(t, 800, 640, 656, 752, 525, 480, 490, 492, 1'b0, pe);
    e.b = model(t, 800, 640, 656, 752, 12, 6, 8, 10, 1'b0, pe);
    e.c = model(t, 8, 4, 5, 7, 6, 3, 4, 5, 1'b1, pe);
    return e;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s (tick %0d): got x=%0d y=%0d hs=%b vs=%b von=%b le=%b fe=%b, want x=%0d y=%0d hs=%b vs=%b von=%b le=%b fe=%b",
               name, tick, got.x, got.y, got.hs, got.vs, got.von, got.le, got.fe,
               want.x, want.y, want.hs, want.vs, want.von, want.le, want.fe);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic grab_all(output obs_t oa, output obs_t ob, output obs_t oc);
    oa = mk(int'(a_x), int'(a_y), a_hs, a_vs, a_von, a_le, a_fe);
    ob = mk(int'(b_x), int'(b_y), b_hs, b_vs, b_von, b_le, b_fe);
    oc = mk(int'(c_x), int'(c_y), c_hs, c_vs, c_von, c_le, c_fe);
  endtask

  // One Clk cycle: drive pix_en, queue the expectation, compare at the falling edge.
  task automatic step(input logic pe, output obs_t ob);
    exp_t e;
    obs_t oa;
    obs_t oc;
    pix_en = pe;
    sb_q.push_back(exp_all(tick, pe));
    @(negedge Clk);
    e = sb_q.pop_front();
    grab_all(oa, ob, oc);
    check("cyc_a", oa, e.a);
    check("cyc_b", ob, e.b);
    check("cyc_c", oc, e.c);
    if (pe && stat_b_en && tick < 9600) begin
      vo_b    += int'(ob.von);
      hs_lo_b += int'(!ob.hs);
      vs_lo_b += int'(!ob.vs);
      le_b    += int'(ob.le);
      fe_b    += int'(ob.fe);
    end
    if (pe && stat_c_en) begin
      vo_c    += int'(oc.von);
      hs_hi_c += int'(oc.hs);
      vs_hi_c += int'(oc.vs);
      fe_c    += int'(oc.fe);
    end
    if (ob.le) le_cyc_q.push_back(cyc);
    cyc++;
    @(posedge Clk);
    if (pe) tick++;
    #1;
  endtask

  task automatic check_in_reset(input string tag);
    exp_t e;
    obs_t oa, ob, oc;
    e = exp_all(0, 1'b0);
    grab_all(oa, ob, oc);
    check({tag, "_a"}, oa, e.a);
    check({tag, "_b"}, ob, e.b);
    check({tag, "_c"}, oc, e.c);
`ifdef VGA_FRAME_CNT_EN
    check_int({tag, "_fc"}, int'(c_fc), 0);
`endif
  endtask

  // Asserts reset between clock edges, checks the immediate clear, releases on a falling edge.
  task automatic do_reset();
    pix_en = 1'b0;
    #2 reset = 1'b0;
    #1 check_in_reset("async_rst");
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    reset = 1'b1;
    tick = 0;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t ob;
    vecs[0]  = '{0,    1'b0, mk(0,   0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
    vecs[1]  = '{639,  1'b1, mk(639, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
    vecs[2]  = '{640,  1'b1, mk(640, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
    vecs[3]  = '{655,  1'b1, mk(655, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
    vecs[4]  = '{656,  1'b1, mk(656, 0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
    vecs[5]  = '{751,  1'b1, mk(751, 0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
    vecs[6]  = '{752,  1'b1, mk(752, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
    vecs[7]  = '{799,  1'b1, mk(799, 0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0)};
    vecs[8]  = '{800,  1'b0, mk(0,   1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
    vecs[9]  = '{4639, 1'b1, mk(639, 5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
    vecs[10] = '{4800, 1'b1, mk(0,   6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
    vecs[11] = '{6400, 1'b1, mk(0,   8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
    vecs[12] = '{7999, 1'b1, mk(799, 9,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0)};
    vecs[13] = '{8000, 1'b1, mk(0,   10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
    vecs[14] = '{9599, 1'b1, mk(799, 11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1)};
    vecs[15] = '{9600, 1'b0, mk(0,   0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
    vecs[16] = '{9601, 1'b0, mk(1,   0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};

    reset  = 1'b0;
    pix_en = 1'b0;
    #12 check_in_reset("por");
    @(negedge Clk);
    reset = 1'b1;
    @(posedge Clk);
    #1;
    for (int i = 0; i < 50; i++) step(1'b0, ob);

    stat_b_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      while (tick < vecs[i].tick) step(1'b1, ob);
      step(vecs[i].pe, ob);
      check($sformatf("vec%0d", i), ob, vecs[i].exp);
    end
    stat_b_en = 1'b0;
    check_int("b_video_on_per_frame", vo_b, 3840);
    check_int("b_hsync_low_ticks", hs_lo_b, 1152);
    check_int("b_vsync_low_ticks", vs_lo_b, 1600);
    check_int("b_line_end_per_frame", le_b, 12);
    check_int("b_frame_end_per_frame", fe_b, 1);

    while (tick < 14000) step(1'b1, ob);
    check_int("pre_reset_hcount", int'(b_x), 400);
    do_reset();
    step(1'b1, ob);
    check_int("post_reset_x0", int'(ob.x), 0);
    step(1'b0, ob);
    check_int("first_tick_x", int'(ob.x), 1);

    le_cyc_q.delete();
    for (int i = 0; i < 7000; i++) step((i % 4) == 0, ob);
    check_int("line_end_pulses_1in4", int'(le_cyc_q.size() >= 2), 1);
    if (le_cyc_q.size() >= 2) check_int("line_period_1in4", le_cyc_q[1] - le_cyc_q[0], 3200);

    do_reset();
    stat_c_en = 1'b1;
    for (int i = 0; i < 257 * 48; i++) step(1'b1, ob);
    stat_c_en = 1'b0;
    check_int("c_frame_end_257", fe_c, 257);
    check_int("c_hsync_high_ticks", hs_hi_c, 3084);
    check_int("c_vsync_high_ticks", vs_hi_c, 2056);
    check_int("c_video_on_ticks", vo_c, 3084);
`ifdef VGA_FRAME_CNT_EN
    check_int("c_frame_cnt_after_257", int'(c_fc), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: a horizontal pixel counter and a vertical line counter, with sync pulse, blanking and pixel-coordinate decode. It replaces the fixed 10-bit horizontal-only counter and drives the display pipeline, supplying the pixel address to the pattern/framebuffer logic and hsync/vsync to the DAC pins. Counting advances only on a pixel-enable strobe, so the block can run from the system clock with a divided pixel rate.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_W, 10, horizontal counter width; must satisfy 2^H_W >= H_TOTAL
- V_W, 10, vertical counter width; must satisfy 2^V_W >= V_TOTAL
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- Clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- pix_en  input  1  pixel tick; counters advance only on cycles where it is high
- pix_x  output  H_W  horizontal count
- pix_y  output  V_W  vertical count
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- video_on  output  1  high inside the visible region
- line_end  output  1  one-cycle strobe on the last pixel of each line
- frame_end  output  1  one-cycle strobe on the last pixel of each frame
- frame_cnt  output  8  frame counter (present only with VGA_FRAME_CNT_EN)

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800 by default); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525 by default).
- hcount counts 0..H_TOTAL-1 inclusive and wraps to 0. It never reaches H_TOTAL; the period is exactly H_TOTAL ticks.
- vcount increments only when hcount wraps, counts 0..V_TOTAL-1, and wraps to 0 together with hcount.
- pix_x = hcount and pix_y = vcount (direct register outputs).
- hsync = SYNC_POL when H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC; otherwise it is ~SYNC_POL. vsync uses the same rule on vcount with the V_ parameters.
- video_on = (hcount < H_VISIBLE) && (vcount < V_VISIBLE).
- line_end = pix_en && hcount==H_TOTAL-1.
- frame_end = line_end && vcount==V_TOTAL-1.
- pix_en low: all counters hold, and the decoded outputs stay stable.
- Comparison arithmetic is unsigned, at H_W/V_W bits. Parameter sums are evaluated as 32-bit integers.

## Timing
- Reset (asynchronous assert, synchronous release on Clk): hcount=0, vcount=0, frame_cnt=0. Consequently pix_x=0, pix_y=0, hsync=vsync=~SYNC_POL, video_on=1, line_end=frame_end=0.
- Reset asserted mid-frame clears all counters immediately, without waiting for a clock edge. The first pix_en after release advances hcount to 1.
- Counter update latency: one Clk edge after the pix_en-high cycle.
- Sync, video_on and strobes are combinational decodes of the current counter registers. They have zero cycles of skew relative to pix_x/pix_y.
- Wrap boundary: on the pix_en cycle where hcount==H_TOTAL-1 and vcount==V_TOTAL-1, the next state is hcount=0 and vcount=0, and frame_end is high during that cycle.

## Configuration
- VGA_FRAME_CNT_EN defined: the frame_cnt port exists. It is an 8-bit register that increments on each frame_end and wraps from 255 to 0.
- VGA_FRAME_CNT_EN not defined: the port and its register are omitted. All other behaviour is identical.

## Test plan
- Assert reset, then release it with pix_en=0 for 50 cycles -> pix_x=0, pix_y=0, hsync=vsync=1, video_on=1, and no strobes.
- Drive pix_en continuously high -> hsync is low exactly for hcount 656..751, and line_end pulses every 800 cycles; hcount never reads 800.
- Drive pix_en continuously high for a full frame -> vsync is low for lines 490..491, frame_end fires once per 420000 ticks, and video_on high-count per frame equals 307200.
- Drive pix_en as a 1-in-4 strobe -> counter sequence matches continuous mode; line period is 3200 Clk cycles.
- Assert reset at hcount=400, vcount=300 -> counters read 0 before the next Clk edge, and the subsequent frame timing is nominal.
- With VGA_FRAME_CNT_EN defined, run 257 frames -> frame_cnt reads 1; with SYNC_POL=1, sync pulses are high-active.
